// File: rtl/cache_sram_req_adapter_if.sv
// Request/response channel plus SRAM-port bundle for cache_sram_req_adapter.
// The slave modport is the adapter; the master modport is the requester,
// response consumer and SRAM wrapper side.
interface cache_sram_req_adapter_if #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8
);
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;

    // Request channel
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [BeWidth-1:0]   req_be_i;

    // Read-response channel
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;

    // SRAM wrapper port
    logic                 sram_req_o;
    logic                 sram_we_o;
    logic [AddrWidth-1:0] sram_addr_o;
    logic [DataWidth-1:0] sram_wdata_o;
    logic [BeWidth-1:0]   sram_be_o;
    logic [DataWidth-1:0] sram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        input  rsp_ready_i, sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        output rsp_ready_i, sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );
endinterface

// File: rtl/cache_sram_req_adapter.sv
// Valid/ready front end for one fixed-latency cache SRAM port. Tracks reads
// through the SRAM latency, buffers read data in a credit-protected FIFO and
// zero-sweeps the array after reset or on an init request.
module cache_sram_req_adapter #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_i,
    output logic busy_o,
    cache_sram_req_adapter_if.slave bus
);
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               r_state;
    logic [AddrWidth-1:0] r_sweep;
    logic [Latency-1:0]   r_pipe;
    logic [CntWidth-1:0]  r_outstanding;
    logic [CntWidth-1:0]  r_fifo_cnt;
    logic [PtrWidth-1:0]  r_wptr;
    logic [PtrWidth-1:0]  r_rptr;
    logic [DataWidth-1:0] r_fifo_mem [RspDepth];

    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_rd_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_rsp_valid;
    logic [Latency-1:0]   w_pipe_next;

    // Credit check: a read is only taken if its response has a guaranteed slot.
    assign w_req_ready = !rst_i && (r_state == ST_RUN)
                         && (r_outstanding < CntWidth'(RspDepth));
    assign w_accept    = w_req_ready && bus.req_valid_i;
    assign w_rd_accept = w_accept && !bus.req_we_i;
    assign w_push      = !rst_i && r_pipe[Latency-1];
    assign w_rsp_valid = !rst_i && (r_fifo_cnt != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready_i;
    assign w_full      = (r_fifo_cnt == CntWidth'(RspDepth));

    assign bus.req_ready_o = w_req_ready;
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_rdata_o = r_fifo_mem[r_rptr];
    assign busy_o          = rst_i || (r_state != ST_RUN);

    if (Latency == 1) begin : g_pipe_single
        assign w_pipe_next = w_rd_accept;
    end else begin : g_pipe_multi
        assign w_pipe_next = {r_pipe[Latency-2:0], w_rd_accept};
    end

    // SRAM port: sweep writes in INIT, pass-through of the accepted request in RUN.
    always_comb begin
        bus.sram_req_o   = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_wdata_o = '0;
        bus.sram_be_o    = '0;
        if (!rst_i) begin
            case (r_state)
                ST_INIT: begin
                    bus.sram_req_o  = 1'b1;
                    bus.sram_we_o   = 1'b1;
                    bus.sram_addr_o = r_sweep;
                    bus.sram_be_o   = '1;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        bus.sram_req_o   = 1'b1;
                        bus.sram_we_o    = bus.req_we_i;
                        bus.sram_addr_o  = bus.req_addr_i;
                        bus.sram_wdata_o = bus.req_wdata_i;
                        bus.sram_be_o    = bus.req_be_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Mode FSM and sweep address counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_sweep == AddrWidth'(NumWords - 1)) begin
                        r_state <= ST_RUN;
                        r_sweep <= '0;
                    end else begin
                        r_sweep <= r_sweep + AddrWidth'(1);
                    end
                end
                ST_RUN: begin
                    if (init_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Wait for every in-flight read to land in the FIFO.
                    if (r_pipe == '0) begin
                        r_state <= ST_INIT;
                        r_sweep <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_sweep <= '0;
                end
            endcase
        end
    end

    // Read-latency valid pipe and outstanding-credit counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pipe        <= '0;
            r_outstanding <= '0;
        end else begin
            r_pipe <= w_pipe_next;
            if (w_rd_accept && !w_pop) begin
                r_outstanding <= r_outstanding + CntWidth'(1);
            end else if (!w_rd_accept && w_pop) begin
                r_outstanding <= r_outstanding - CntWidth'(1);
            end
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PtrWidth'(RspDepth - 1)) ? '0 : r_wptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrWidth'(RspDepth - 1)) ? '0 : r_rptr + PtrWidth'(1);
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + CntWidth'(1);
            end else if (!w_push && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - CntWidth'(1);
            end
        end
    end

    // Response FIFO storage; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= bus.sram_rdata_i;
        end
    end

    // Credit gating must make a push into a full FIFO impossible.
    assert property (@(posedge clk_i) disable iff (rst_i) w_push |-> !w_full);

endmodule

// File: doc/cache_sram_req_adapter.md
# cache_sram_req_adapter

Single-port request/response adapter in front of one port of the cache SRAM wrapper. It turns a valid/ready request channel into the SRAM's fixed-latency `req/we/addr/wdata/be` interface. It tracks in-flight reads through the `Latency` pipeline and buffers read data in a credit-protected response FIFO, so a stalled consumer never loses data. After reset, and on demand, it also sweeps the whole array to zero before accepting traffic.

## Interface
- `NumWords`, 1024, SRAM depth in words
- `DataWidth`, 128, data bits per word
- `ByteWidth`, 8, bits per byte-enable lane
- `Latency`, 1, SRAM read latency in cycles (>=1), identical to the wrapper's setting
- `RspDepth`, 3, response FIFO entries (>=1); sustained 1 read/cycle requires `RspDepth >= Latency+2`
- `AddrWidth`, `$clog2(NumWords)` (1 if `NumWords`==1); `BeWidth`, `ceil(DataWidth/ByteWidth)`

Ports:
- `clk_i` in 1: the only clock
- `rst_i` in 1: synchronous, active-high reset
- `init_i` in 1: pulse requesting a full-array zero sweep
- `busy_o` out 1: high while in reset, DRAIN or INIT
- `req_valid_i` in 1, `req_ready_o` out 1: request handshake
- `req_we_i` in 1: 1 = write, 0 = read
- `req_addr_i` in AddrWidth, `req_wdata_i` in DataWidth, `req_be_i` in BeWidth: request fields
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: read-response handshake
- `rsp_rdata_o` out DataWidth: read data, head of FIFO
- `sram_req_o`, `sram_we_o` out 1: to the wrapper port
- `sram_addr_o` out AddrWidth, `sram_wdata_o` out DataWidth, `sram_be_o` out BeWidth: to the wrapper port
- `sram_rdata_i` in DataWidth: from the wrapper port

## Operation
- States: INIT, RUN, DRAIN. Reset enters INIT with sweep counter 0 and clears the FIFO, read pipeline and counters.
- INIT:
  - Each cycle drives `sram_req_o`=1, `sram_we_o`=1, `sram_addr_o`=counter, `sram_wdata_o`=0, `sram_be_o`=all ones.
  - The counter increments; after writing `NumWords-1` the state moves to RUN.
  - `req_ready_o`=0 throughout.
- RUN:
  - `req_ready_o` = (`outstanding < RspDepth`), where `outstanding` = reads in the Latency pipeline + FIFO occupancy.
  - `req_ready_o` does not depend combinationally on `rsp_ready_i` or `req_valid_i`.
  - On accept (valid&ready), the request fields drive the SRAM outputs combinationally in the same cycle and `sram_req_o`=1. Otherwise `sram_req_o`=0.
  - Writes produce no response and do not consume credit.
  - A read shifts a 1 into a `Latency`-deep valid shift register. When the flag exits, `sram_rdata_i` is pushed into the FIFO.
- `init_i` in RUN moves to DRAIN. DRAIN holds `req_ready_o`=0 until the read pipeline is empty, then enters INIT with counter 0.
- FIFO contents survive DRAIN/INIT and remain poppable. `init_i` is ignored in DRAIN and INIT.
- FIFO: `rsp_valid_o` = not empty; a pop happens on `rsp_valid_o & rsp_ready_i`. A push and pop in the same cycle are both performed and occupancy is unchanged. Credit gating guarantees no push when full; an assertion checks this.
- `outstanding` update: +1 on a read accept, -1 on a pop; simultaneous events net to 0.
- Reset mid-operation discards in-flight reads and FIFO data and restarts INIT.

## Timing
- While `rst_i`=1: `req_ready_o`, `rsp_valid_o`, `sram_req_o`, `sram_we_o` are 0; addr/wdata/be are 0; `rsp_rdata_o` is don't-care; `busy_o`=1.
- The first sweep write occurs in the first cycle after `rst_i` falls. Sweep takes exactly `NumWords` cycles.
- `req_ready_o` can first be 1 in cycle `NumWords` after deassertion.
- A read accepted in cycle T: the wrapper returns data in cycle T+Latency, it is captured at the end of that cycle, and `rsp_valid_o`=1 from cycle T+Latency+1.
- Write acceptance to SRAM write: 0 cycles (same cycle).
- `busy_o` is registered-state decoded. It falls in the cycle RUN is entered.
- Back-to-back reads: one accept per cycle is possible when `RspDepth >= Latency+2` and the consumer pops every cycle.

## Test plan
- Reset sweep, `NumWords`=16, `Latency`=1: deassert `rst_i` -> 16 consecutive writes to addresses 0..15 with data 0 and be all-ones; `req_ready_o` rises in cycle 16; a read of address 7 then returns 0.
- Write address 3 = 0xA5 with be all-ones, then read address 3 -> `rsp_valid_o` 2 cycles after the read accept, with `rsp_rdata_o`=0xA5.
- Partial write: write 0xFF..FF, then be=0x0001 with data 0 -> read returns 0xFF..FF00.
- Backpressure, `RspDepth`=3, `rsp_ready_i`=0: issue 5 reads -> exactly 3 accepted and `req_ready_o`=0; raise `rsp_ready_i` -> 3 responses in order, then the remaining 2 are accepted and returned in order.
- Streaming, `RspDepth`=3, `Latency`=1, `rsp_ready_i`=1: 8 back-to-back reads -> accepted in 8 consecutive cycles, 8 consecutive responses, no ready drop.
- `init_i` with 2 reads in flight -> DRAIN until both are captured, both responses still delivered, then a 16-cycle sweep; `busy_o`=1 throughout; `rst_i` asserted mid-sweep restarts the sweep at address 0.
